// File: rtl/instr_fetch_decode_if.sv
// Bus between the CPU controller and the fetch/decode stage.
// master: controller side (drives strobes, memory data, C register; sees PC/IR/decode).
// slave : instr_fetch_decode side.
// Signals: loadir, loadpc, msel, nsel, mdata, cout (controller -> stage);
//          mem_addr, pc, ir, opcode, op, readnum, writenum, shift,
//          sximm8, sximm5 (stage -> controller/datapath).
interface instr_fetch_decode_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          loadir;
  logic          loadpc;
  logic          msel;
  logic [1:0]    nsel;
  logic [DW-1:0] mdata;
  logic [DW-1:0] cout;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic [1:0]    shift;
  logic [DW-1:0] sximm8;
  logic [DW-1:0] sximm5;

  modport master (
    output loadir, loadpc, msel, nsel, mdata, cout,
    input  mem_addr, pc, ir, opcode, op, readnum, writenum, shift, sximm8, sximm5
  );

  modport slave (
    input  loadir, loadpc, msel, nsel, mdata, cout,
    output mem_addr, pc, ir, opcode, op, readnum, writenum, shift, sximm8, sximm5
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode stage.
// Holds the program counter and instruction register, forms the memory address
// (PC or datapath C register) and decodes the IR for controller and datapath.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high, clears PC and IR (overrides strobes)
//   bus   - instr_fetch_decode_if.slave: strobes loadir/loadpc/msel/nsel,
//           mdata, cout in; mem_addr, pc, ir and decoded fields out.
module instr_fetch_decode #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_decode_if.slave bus
);

  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [2:0]    regnum;

  // IR and PC may load on the same edge: IR captures the word addressed by
  // the pre-increment PC, then PC advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (bus.loadpc) pc_q <= pc_q + 1'b1;
      if (bus.loadir) ir_q <= bus.mdata;
    end
  end

  always_comb begin
    regnum = '0;
    unique case (bus.nsel)
      2'b00:   regnum = ir_q[10:8];
      2'b01:   regnum = ir_q[7:5];
      2'b10:   regnum = ir_q[2:0];
      default: regnum = '0;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.mem_addr = bus.msel ? bus.cout[AW-1:0] : pc_q;
  assign bus.opcode   = ir_q[15:13];
  assign bus.op       = ir_q[12:11];
  assign bus.readnum  = regnum;
  assign bus.writenum = regnum;
  assign bus.shift    = ir_q[4:3];
  assign bus.sximm8   = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{(DW-5){ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_decode_if #(.AW(8), .DW(16)) bus ();

  instr_fetch_decode #(.AW(8), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ldir, ldpc, msel;
    logic [1:0]  nsel;
    logic [15:0] mdata, cout;
    logic [7:0]  exp_pc;
    logic [15:0] exp_ir;
    logic [7:0]  exp_addr;
    logic [2:0]  exp_rn;
    logic [1:0]  exp_shift;
    logic [15:0] exp_sx8, exp_sx5;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  int pc_m, ir_m;

  function automatic int fld(int x, int lo, int n);
    return (x / (1 << lo)) % (1 << n);
  endfunction

  function automatic int m_rn(int ir, int nsel);
    case (nsel)
      0: return fld(ir, 8, 3);
      1: return fld(ir, 5, 3);
      2: return fld(ir, 0, 3);
      default: return 0;
    endcase
  endfunction

  function automatic int m_sx8(int ir);
    int v = ir % 256;
    return (v >= 128) ? v + 65280 : v;
  endfunction

  function automatic int m_sx5(int ir);
    int v = ir % 32;
    return (v >= 16) ? v + 65504 : v;
  endfunction

  task automatic drive(input logic r, input logic li, input logic lp, input logic ms,
                       input logic [1:0] ns, input logic [15:0] md, input logic [15:0] co);
    reset = r; bus.loadir = li; bus.loadpc = lp; bus.msel = ms;
    bus.nsel = ns; bus.mdata = md; bus.cout = co;
  endtask

  task automatic check_all_vs_model(input string tag, input int ms, input int ns, input int co);
    int addr_e;
    addr_e = ms ? (co % 256) : pc_m;
    check({tag, ".pc"},       32'(bus.pc),       32'(pc_m));
    check({tag, ".ir"},       32'(bus.ir),       32'(ir_m));
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr_e));
    check({tag, ".readnum"},  32'(bus.readnum),  32'(m_rn(ir_m, ns)));
    check({tag, ".writenum"}, 32'(bus.writenum), 32'(m_rn(ir_m, ns)));
    check({tag, ".opcode"},   32'(bus.opcode),   32'(ir_m / 8192));
    check({tag, ".op"},       32'(bus.op),       32'(fld(ir_m, 11, 2)));
    check({tag, ".shift"},    32'(bus.shift),    32'(fld(ir_m, 3, 2)));
    check({tag, ".sximm8"},   32'(bus.sximm8),   32'(m_sx8(ir_m)));
    check({tag, ".sximm5"},   32'(bus.sximm5),   32'(m_sx5(ir_m)));
  endtask

  initial begin
    //          rst  ldir ldpc msel nsel   mdata     cout      pc    ir        addr  rn    sh     sx8       sx5
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 8'd0, 16'h0000, 8'd0, 3'd0, 2'd0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 8'd0, 16'h0000, 8'd0, 3'd0, 2'd0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'hD105, 16'h0000, 8'd0, 16'hD105, 8'd0, 3'd1, 2'd0, 16'h0005, 16'h0005};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'h0000, 16'h0000, 8'd1, 16'hD105, 8'd1, 3'd0, 2'd0, 16'h0005, 16'h0005};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'hA2B3, 16'h0000, 8'd1, 16'hA2B3, 8'd1, 3'd2, 2'd2, 16'hFFB3, 16'hFFF3};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h0000, 8'd1, 16'hA2B3, 8'd1, 3'd5, 2'd2, 16'hFFB3, 16'hFFF3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 16'h0000, 8'd1, 16'hA2B3, 8'd1, 3'd3, 2'd2, 16'hFFB3, 16'hFFF3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 8'd1, 16'hA2B3, 8'd1, 3'd0, 2'd2, 16'hFFB3, 16'hFFF3};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h60F1, 16'h1234, 8'd1, 16'h60F1, 8'h34, 3'd0, 2'd2, 16'hFFF1, 16'hFFF1};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h600F, 16'h1234, 8'd2, 16'h600F, 8'd2, 3'd0, 2'd1, 16'h000F, 16'h000F};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(posedge clk); #1;

    // Table: apply, one edge, check with inputs still held
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].ldir, tbl[i].ldpc, tbl[i].msel, tbl[i].nsel, tbl[i].mdata, tbl[i].cout);
      @(posedge clk); #1;
      check($sformatf("tbl%0d.pc", i),       32'(bus.pc),       32'(tbl[i].exp_pc));
      check($sformatf("tbl%0d.ir", i),       32'(bus.ir),       32'(tbl[i].exp_ir));
      check($sformatf("tbl%0d.mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].exp_addr));
      check($sformatf("tbl%0d.readnum", i),  32'(bus.readnum),  32'(tbl[i].exp_rn));
      check($sformatf("tbl%0d.writenum", i), 32'(bus.writenum), 32'(tbl[i].exp_rn));
      check($sformatf("tbl%0d.shift", i),    32'(bus.shift),    32'(tbl[i].exp_shift));
      check($sformatf("tbl%0d.sximm8", i),   32'(bus.sximm8),   32'(tbl[i].exp_sx8));
      check($sformatf("tbl%0d.sximm5", i),   32'(bus.sximm5),   32'(tbl[i].exp_sx5));
    end
    check("tbl.d105_opcode", 32'(bus.opcode), 32'(3'b011)); // IR=600F -> opcode 3
    check("tbl.d105_op",     32'(bus.op),     32'(2'b00));

    // Reset mid-stream, readnum 0 for every nsel
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0);
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      bus.nsel = 2'(n); #1;
      check($sformatf("rst.readnum%0d", n), 32'(bus.readnum), 32'd0);
    end

    // PC wrap 255 -> 0
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (255) @(posedge clk);
    #1;
    check("wrap.pc255", 32'(bus.pc), 32'd255);
    check("wrap.addr255", 32'(bus.mem_addr), 32'd255);
    @(posedge clk); #1;
    check("wrap.pc0", 32'(bus.pc), 32'd0);

    // Simultaneous loadir/loadpc at PC=7
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (7) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h8000, 16'h0);
    #1;
    check("simul.addr_capture", 32'(bus.mem_addr), 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    #1;
    check("simul.ir", 32'(bus.ir), 32'h8000);
    check("simul.pc", 32'(bus.pc), 32'd8);

    // Randomised run against the reference model
    pc_m = 8; ir_m = 16'h8000;
    for (int k = 0; k < 400; k++) begin
      int r, li, lp, ms, ns, md, co;
      r  = ($urandom_range(0, 19) == 0);
      li = $urandom_range(0, 1);
      lp = $urandom_range(0, 1);
      ms = $urandom_range(0, 1);
      ns = $urandom_range(0, 3);
      md = $urandom_range(0, 65535);
      co = $urandom_range(0, 65535);
      drive(1'(r), 1'(li), 1'(lp), 1'(ms), 2'(ns), 16'(md), 16'(co));
      #1;
      check_all_vs_model($sformatf("rnd%0d", k), ms, ns, co);
      @(posedge clk);
      if (r != 0) begin
        pc_m = 0; ir_m = 0;
      end else begin
        if (li != 0) ir_m = md;
        if (lp != 0) pc_m = (pc_m + 1) % 256;
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and decode stage feeding the CPU controller. Holds the program counter (PC) and instruction register (IR), and generates the memory address from the PC or the datapath result. Decodes the IR into opcode/op for the controller and into register numbers, shift and sign-extended immediates for the datapath. All state changes are driven by the controller strobes `loadir`, `loadpc`, `msel` and `nsel`.

## Interface
Parameters:
- `AW`, 8, memory address / PC width
- `DW`, 16, instruction and data word width (fixed encoding assumes 16)

Ports:
- `clk`  in  1  clock; all registers update on rising edge
- `reset`  in  1  synchronous, active-high; clears PC and IR
- `loadir`  in  1  latch `mdata` into IR at the next edge
- `loadpc`  in  1  PC ← PC+1 at the next edge
- `msel`  in  1  address select: 0 = PC, 1 = `cout[AW-1:0]`
- `nsel`  in  2  register-number select: 00 = Rn, 01 = Rd, 10 = Rm, 11 = 3'd0
- `mdata`  in  DW  memory read data
- `cout`  in  DW  datapath C register (load/store address)
- `mem_addr`  out  AW  memory address, combinational from `msel`
- `pc`  out  AW  current PC
- `ir`  out  DW  current IR
- `opcode`  out  3  IR[15:13]
- `op`  out  2  IR[12:11]
- `readnum`  out  3  selected register number
- `writenum`  out  3  same value as `readnum`
- `shift`  out  2  IR[4:3]
- `sximm8`  out  DW  IR[7:0] sign-extended
- `sximm5`  out  DW  IR[4:0] sign-extended

## Operation
- Field map: Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0], shift = IR[4:3], imm8 = IR[7:0], imm5 = IR[4:0].
- PC register:
  - `reset` → 0.
  - Else if `loadpc`, PC ← PC+1 modulo 2^AW; 255 wraps to 0 when AW=8.
  - Otherwise held.
- IR register:
  - `reset` → 0.
  - Else if `loadir`, IR ← `mdata`.
  - Otherwise held.
- `reset` has priority over `loadir` and `loadpc` in the same cycle.
- `loadir` and `loadpc` may be asserted together; both take effect on the same edge.
  - IR captures the word fetched at the pre-increment address.
  - PC then advances.
- `mem_addr = msel ? cout[AW-1:0] : pc`. This is purely combinational, with no register.
- `readnum`/`writenum` form a combinational mux on `nsel` over the current IR fields.
- Sign extension:
  - `sximm8` replicates bit 7 into bits [15:8].
  - `sximm5` replicates bit 4 into bits [15:5].
- The block contains no FSM of its own. The sequencing (fetch state → `loadir`, next state → `loadpc`) is owned by the controller; this block must honour any strobe pattern.

## Timing
- Reset values: PC = 0, IR = 0.
  - Consequently `opcode` = 0, `op` = 0, `shift` = 0, `sximm8` = 0, `sximm5` = 0.
  - `mem_addr` = 0 when `msel` = 0; `readnum` = `writenum` = 0 for every `nsel`.
- Latency:
  - `loadir`/`loadpc` take effect one edge after they are sampled high.
  - Decoded outputs follow IR in the same cycle (combinational from IR).
- Memory read is assumed synchronous by the controller: `mdata` must be valid in the cycle `loadir` is sampled. This block adds no wait states.
- `msel` and `nsel` changes propagate within the same cycle; no registered delay.
- Reset asserted mid-instruction clears PC/IR at that edge; the controller restarts fetch from address 0.

## Test plan
- **Reset with strobes:** hold `reset`=1 with `loadir`=`loadpc`=1 and `mdata`=16'hFFFF for 2 cycles.
  - Expect PC=0, IR=0, `sximm8`=0, `readnum`=0.
- **Fetch sequence:** release reset, `mdata`=16'hD105 (MOV R1,#5), pulse `loadir` for 1 cycle, then `loadpc` for 1 cycle.
  - After `loadir`: IR=16'hD105, `opcode`=3'b110, `op`=2'b10, `sximm8`=16'h0005.
  - After `loadpc`: PC=1.
- **Register select and shift:** IR=16'hA2B3.
  - `nsel`=00 → 2; `nsel`=01 → 5; `nsel`=10 → 3; `nsel`=11 → 0; `shift`=2'b10.
- **Sign extension:** IR=16'h60F1 → `sximm8`=16'hFFF1, `sximm5`=16'hFFF1. IR=16'h600F → `sximm5`=16'h000F.
- **Address mux and PC wrap:**
  - PC=8'hFF, `loadpc`=1 → PC=8'h00.
  - `msel`=1 with `cout`=16'h1234 → `mem_addr`=8'h34; `msel`=0 → `mem_addr`=PC.
- **Simultaneous strobes:** PC=7, `mdata`=16'h8000, `loadir`=`loadpc`=1 for 1 cycle.
  - Expect IR=16'h8000, PC=8.
  - `mem_addr` was 7 during the capture cycle.
